// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout fetch has absolute priority, CPU requests queue in a FIFO.
// Build option VRAM_ARB_STATS_EN adds CLR_STATS / STALL_COUNT fetch-stall statistics.
module vram_arbiter #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              PIXEL_CLOCK,
   input  logic              RESET_N,
   input  logic              FETCH_REQ,
   input  logic [ADDR_W-1:0] FETCH_ADDR,
   output logic [DATA_W-1:0] FETCH_DATA,
   output logic              FETCH_VALID,
   input  logic              CPU_REQ,
   input  logic              CPU_WE,
   input  logic [ADDR_W-1:0] CPU_ADDR,
   input  logic [DATA_W-1:0] CPU_WDATA,
   output logic              CPU_READY,
   output logic [DATA_W-1:0] CPU_RDATA,
   output logic              CPU_RVALID,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [DATA_W-1:0] RAM_WDATA,
   output logic              RAM_WE,
   input  logic [DATA_W-1:0] RAM_RDATA
`ifdef VRAM_ARB_STATS_EN
   ,
   input  logic              CLR_STATS,
   output logic [15:0]       STALL_COUNT
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      TAG_NONE   = 2'd0,
      TAG_FETCH  = 2'd1,
      TAG_CPU_RD = 2'd2
   } tag_e;

   logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
   logic              r_fifo_we   [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              r_ready;

   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic              r_ram_we;
   tag_e              r_tag1;
   tag_e              r_tag2;
   logic [DATA_W-1:0] r_fetch_data;
   logic              r_fetch_valid;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic              r_cpu_rvalid;

   logic              w_push;
   logic              w_pop;
   logic              w_fifo_nonempty;
   logic [PTR_W:0]    w_count_nxt;

   // CPU handshake: a request transfers on an edge where CPU_REQ and CPU_READY are both high.
   // CPU_READY is registered and reports whether the FIFO has room after the current edge.
   assign w_fifo_nonempty = (r_count != '0);
   assign w_push          = CPU_REQ & r_ready;
   assign w_pop           = ~FETCH_REQ & w_fifo_nonempty;
   assign w_count_nxt     = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

   always_ff @(posedge PIXEL_CLOCK) begin
      if (RESET_N && w_push) begin
         r_fifo_addr[r_wr_ptr] <= CPU_ADDR;
         r_fifo_data[r_wr_ptr] <= CPU_WDATA;
         r_fifo_we[r_wr_ptr]   <= CPU_WE;
      end
   end

   always_ff @(posedge PIXEL_CLOCK) begin
      if (!RESET_N) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_ready       <= 1'b0;
         r_ram_addr    <= '0;
         r_ram_wdata   <= '0;
         r_ram_we      <= 1'b0;
         r_tag1        <= TAG_NONE;
         r_tag2        <= TAG_NONE;
         r_fetch_data  <= '0;
         r_fetch_valid <= 1'b0;
         r_cpu_rdata   <= '0;
         r_cpu_rvalid  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt < DEPTH_C);
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

         if (FETCH_REQ) begin
            r_ram_addr <= FETCH_ADDR;
            r_ram_we   <= 1'b0;
            r_tag1     <= TAG_FETCH;
         end else if (w_fifo_nonempty) begin
            r_ram_addr  <= r_fifo_addr[r_rd_ptr];
            r_ram_wdata <= r_fifo_data[r_rd_ptr];
            r_ram_we    <= r_fifo_we[r_rd_ptr];
            r_tag1      <= r_fifo_we[r_rd_ptr] ? TAG_NONE : TAG_CPU_RD;
         end else begin
            r_ram_we <= 1'b0;
            r_tag1   <= TAG_NONE;
         end

         // Stage 2 lines up with RAM_RDATA of the access issued two edges earlier.
         r_tag2        <= r_tag1;
         r_fetch_valid <= (r_tag2 == TAG_FETCH);
         r_cpu_rvalid  <= (r_tag2 == TAG_CPU_RD);
         if (r_tag2 == TAG_FETCH)  r_fetch_data <= RAM_RDATA;
         if (r_tag2 == TAG_CPU_RD) r_cpu_rdata  <= RAM_RDATA;
      end
   end

`ifdef VRAM_ARB_STATS_EN
   logic [15:0] r_stall_count;

   always_ff @(posedge PIXEL_CLOCK) begin
      if (!RESET_N || CLR_STATS) begin
         r_stall_count <= '0;
      end else if (FETCH_REQ && w_fifo_nonempty && (r_stall_count != 16'hFFFF)) begin
         r_stall_count <= r_stall_count + 16'd1;
      end
   end

   assign STALL_COUNT = r_stall_count;
`endif

   assign FETCH_DATA  = r_fetch_data;
   assign FETCH_VALID = r_fetch_valid;
   assign CPU_READY   = r_ready;
   assign CPU_RDATA   = r_cpu_rdata;
   assign CPU_RVALID  = r_cpu_rvalid;
   assign RAM_ADDR    = r_ram_addr;
   assign RAM_WDATA   = r_ram_wdata;
   assign RAM_WE      = r_ram_we;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: queue-based reference model, directed vector table and random traffic.
// Define VRAM_ARB_STATS_EN to also exercise the stall statistics.
module tb_vram_arbiter;

   localparam int AW    = 15;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wd;
   logic          clr;

   logic [DW-1:0] fetch_data;
   logic          fetch_valid;
   logic          cpu_ready;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rvalid;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;
`ifdef VRAM_ARB_STATS_EN
   logic [15:0]   stall_count;
`endif

   // clock / reset block
   always #5 clk = ~clk;

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .PIXEL_CLOCK (clk),
      .RESET_N     (rst_n),
      .FETCH_REQ   (f_req),
      .FETCH_ADDR  (f_addr),
      .FETCH_DATA  (fetch_data),
      .FETCH_VALID (fetch_valid),
      .CPU_REQ     (c_req),
      .CPU_WE      (c_we),
      .CPU_ADDR    (c_addr),
      .CPU_WDATA   (c_wd),
      .CPU_READY   (cpu_ready),
      .CPU_RDATA   (cpu_rdata),
      .CPU_RVALID  (cpu_rvalid),
      .RAM_ADDR    (ram_addr),
      .RAM_WDATA   (ram_wdata),
      .RAM_WE      (ram_we),
      .RAM_RDATA   (ram_rdata)
`ifdef VRAM_ARB_STATS_EN
      ,
      .CLR_STATS   (clr),
      .STALL_COUNT (stall_count)
`endif
   );

   // Synchronous VRAM: data for an address presented in one cycle appears after the next edge.
   logic [DW-1:0] vram [512];
   logic          ld_en;
   logic [8:0]    ld_addr;
   logic [DW-1:0] ld_data;

   always @(posedge clk) begin
      if (ld_en) begin
         vram[ld_addr] <= ld_data;
      end else begin
         ram_rdata <= vram[ram_addr[8:0]];
         if (ram_we) vram[ram_addr[8:0]] <= ram_wdata;
      end
   end

   // reference model: memory image, CPU request queue, scheduled deliveries
   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
   } req_t;

   logic [DW-1:0] mmem [512];
   req_t          m_q[$];
   logic [DW-1:0] exp_q[$];
   int            exp_due_q[$];
   logic [DW-1:0] fexp_q[$];
   int            fdue_q[$];
   int            cyc;
   logic          m_ready, m_we, m_fvalid, m_cvalid;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_fdata, m_cdata;
   logic [15:0]   m_stall;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_edge(input logic s_rst, input logic s_freq, input logic [AW-1:0] s_faddr,
                             input logic s_creq, input logic s_cwe, input logic [AW-1:0] s_caddr,
                             input logic [DW-1:0] s_cwd, input logic s_clr);
      req_t e;
      cyc++;
      if (!s_rst) begin
         m_q.delete(); exp_q.delete(); exp_due_q.delete(); fexp_q.delete(); fdue_q.delete();
         m_ready = 0; m_we = 0; m_addr = '0; m_wdata = '0;
         m_fvalid = 0; m_cvalid = 0; m_fdata = '0; m_cdata = '0; m_stall = '0;
         return;
      end
      m_fvalid = 0;
      if (fdue_q.size() > 0 && fdue_q[0] == cyc) begin
         m_fvalid = 1; m_fdata = fexp_q.pop_front(); void'(fdue_q.pop_front());
      end
      m_cvalid = 0;
      if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
         m_cvalid = 1; m_cdata = exp_q.pop_front(); void'(exp_due_q.pop_front());
      end
      if (s_clr) m_stall = '0;
      else if (s_freq && m_q.size() > 0 && m_stall != 16'hFFFF) m_stall++;
      if (s_freq) begin
         m_addr = s_faddr; m_we = 0;
         fexp_q.push_back(mmem[s_faddr[8:0]]); fdue_q.push_back(cyc + 2);
      end else if (m_q.size() > 0) begin
         e = m_q.pop_front();
         m_addr = e.addr; m_we = e.we; m_wdata = e.wd;
         if (e.we) mmem[e.addr[8:0]] = e.wd;
         else begin exp_q.push_back(mmem[e.addr[8:0]]); exp_due_q.push_back(cyc + 2); end
      end else begin
         m_we = 0;
      end
      if (s_creq && m_ready) begin
         e.we = s_cwe; e.addr = s_caddr; e.wd = s_cwd;
         m_q.push_back(e);
      end
      m_ready = (m_q.size() < DEPTH);
   endtask

   // driver: one clock edge, then model update and full output comparison
   task automatic tick();
      logic s_rst, s_freq, s_creq, s_cwe, s_clr;
      logic [AW-1:0] s_faddr, s_caddr;
      logic [DW-1:0] s_cwd;
      s_rst = rst_n; s_freq = f_req; s_faddr = f_addr; s_creq = c_req;
      s_cwe = c_we; s_caddr = c_addr; s_cwd = c_wd; s_clr = clr;
      @(posedge clk);
      #1;
      model_edge(s_rst, s_freq, s_faddr, s_creq, s_cwe, s_caddr, s_cwd, s_clr);
      chk("fetch_valid", 32'(fetch_valid), 32'(m_fvalid));
      chk("fetch_data",  32'(fetch_data),  32'(m_fdata));
      chk("cpu_rvalid",  32'(cpu_rvalid),  32'(m_cvalid));
      chk("cpu_rdata",   32'(cpu_rdata),   32'(m_cdata));
      chk("cpu_ready",   32'(cpu_ready),   32'(m_ready));
      chk("ram_we",      32'(ram_we),      32'(m_we));
      chk("ram_addr",    32'(ram_addr),    32'(m_addr));
      chk("ram_wdata",   32'(ram_wdata),   32'(m_wdata));
`ifdef VRAM_ARB_STATS_EN
      chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
   endtask

   task automatic idle();
      f_req = 0; f_addr = '0; c_req = 0; c_we = 0; c_addr = '0; c_wd = '0; clr = 0;
   endtask

   typedef struct {
      logic          f_req;
      logic [AW-1:0] f_addr;
      logic          c_req;
      logic          c_we;
      logic [AW-1:0] c_addr;
      logic [DW-1:0] c_wd;
      logic          e_ready;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic          e_fvalid;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses, lat, nf, nc, nw;
      rst_n = 0; cyc = 0; ld_en = 0; ld_addr = '0; ld_data = '0;
      idle();

      // preload VRAM and the model image with identical random contents
      for (int i = 0; i < 512; i++) begin
         ld_en = 1; ld_addr = 9'(i); ld_data = DW'($urandom);
         mmem[i] = ld_data;
         @(posedge clk); #1;
      end
      ld_en = 0;

      tick(); tick();
      chk("reset_ready", 32'(cpu_ready), 32'd0);
      chk("reset_we",    32'(ram_we),    32'd0);

      // write 0x5A to 0x0123, then read it back
      rst_n = 1; tick();
      chk("ready_after_reset", 32'(cpu_ready), 32'd1);
      c_req = 1; c_we = 1; c_addr = 15'h0123; c_wd = 8'h5A; tick();
      idle(); tick();
      chk("wr_we",    32'(ram_we),    32'd1);
      chk("wr_addr",  32'(ram_addr),  32'h0123);
      chk("wr_wdata", 32'(ram_wdata), 32'h5A);
      c_req = 1; c_we = 0; c_addr = 15'h0123; tick();
      idle();
      pulses = 0; lat = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) begin
            chk("rd_issue_we",   32'(ram_we),   32'd0);
            chk("rd_issue_addr", 32'(ram_addr), 32'h0123);
         end
         if (cpu_rvalid) begin
            pulses++;
            if (lat == 0) lat = k;
            chk("rd_data", 32'(cpu_rdata), 32'h5A);
         end
      end
      chk("rd_pulses",  32'(pulses), 32'd1);
      chk("rd_latency", 32'(lat),    32'd3);

      // fetch burst with CPU writes filling the FIFO, then draining in order
      vecs[0]  = '{1'b1, 15'h070, 1'b1, 1'b1, 15'h100, 8'hA0, 1'b1, 1'b0, 15'h070, 1'b0};
      vecs[1]  = '{1'b1, 15'h071, 1'b1, 1'b1, 15'h101, 8'hA1, 1'b1, 1'b0, 15'h071, 1'b0};
      vecs[2]  = '{1'b1, 15'h072, 1'b1, 1'b1, 15'h102, 8'hA2, 1'b1, 1'b0, 15'h072, 1'b1};
      vecs[3]  = '{1'b1, 15'h073, 1'b1, 1'b1, 15'h103, 8'hA3, 1'b0, 1'b0, 15'h073, 1'b1};
      vecs[4]  = '{1'b1, 15'h074, 1'b1, 1'b1, 15'h104, 8'hA4, 1'b0, 1'b0, 15'h074, 1'b1};
      vecs[5]  = '{1'b0, 15'h075, 1'b1, 1'b1, 15'h104, 8'hA4, 1'b1, 1'b1, 15'h100, 1'b1};
      vecs[6]  = '{1'b0, 15'h076, 1'b1, 1'b1, 15'h104, 8'hA4, 1'b1, 1'b1, 15'h101, 1'b1};
      vecs[7]  = '{1'b1, 15'h077, 1'b0, 1'b0, 15'h000, 8'h00, 1'b1, 1'b0, 15'h077, 1'b0};
      vecs[8]  = '{1'b0, 15'h078, 1'b0, 1'b0, 15'h000, 8'h00, 1'b1, 1'b1, 15'h102, 1'b0};
      vecs[9]  = '{1'b0, 15'h079, 1'b0, 1'b0, 15'h000, 8'h00, 1'b1, 1'b1, 15'h103, 1'b1};
      vecs[10] = '{1'b0, 15'h07A, 1'b0, 1'b0, 15'h000, 8'h00, 1'b1, 1'b1, 15'h104, 1'b0};
      vecs[11] = '{1'b0, 15'h07B, 1'b0, 1'b0, 15'h000, 8'h00, 1'b1, 1'b0, 15'h104, 1'b0};
      for (int i = 0; i < 12; i++) begin
         f_req = vecs[i].f_req; f_addr = vecs[i].f_addr; c_req = vecs[i].c_req;
         c_we = vecs[i].c_we; c_addr = vecs[i].c_addr; c_wd = vecs[i].c_wd;
         tick();
         chk($sformatf("vec%0d_ready", i),  32'(cpu_ready),   32'(vecs[i].e_ready));
         chk($sformatf("vec%0d_we", i),     32'(ram_we),      32'(vecs[i].e_we));
         chk($sformatf("vec%0d_addr", i),   32'(ram_addr),    32'(vecs[i].e_addr));
         chk($sformatf("vec%0d_fvalid", i), 32'(fetch_valid), 32'(vecs[i].e_fvalid));
      end
      idle(); tick(); tick();

      // fetch and FIFO head on the same edge: fetch wins, entry issues next free edge
      f_req = 1; f_addr = 15'h0011; c_req = 1; c_we = 1; c_addr = 15'h0150; c_wd = 8'h33; tick();
      c_req = 0; f_addr = 15'h0012; tick();
      chk("tie_fetch_we",   32'(ram_we),   32'd0);
      chk("tie_fetch_addr", 32'(ram_addr), 32'h0012);
      f_req = 0; tick();
      chk("tie_cpu_we",   32'(ram_we),   32'd1);
      chk("tie_cpu_addr", 32'(ram_addr), 32'h0150);
      clr = 1; tick(); clr = 0;
`ifdef VRAM_ARB_STATS_EN
      chk("stall_after_clr", 32'(stall_count), 32'd0);
`endif

      // alternating fetches and CPU reads: tag routing
      for (int i = 0; i < 16; i++) begin
         f_req = i[0]; f_addr = AW'(9'h020 + i);
         c_req = 1; c_we = 0; c_addr = AW'(9'h040 + i);
         tick();
      end
      idle();
      for (int i = 0; i < 12; i++) tick();

      // reset with reads in flight and FIFO entries pending
      for (int i = 0; i < 3; i++) begin
         f_req = 1; f_addr = AW'(9'h060 + i); c_req = 1; c_we = 0; c_addr = AW'(9'h080 + i);
         tick();
      end
      f_req = 0; rst_n = 0; tick();
      chk("mid_reset_we",     32'(ram_we),      32'd0);
      chk("mid_reset_ready",  32'(cpu_ready),   32'd0);
      chk("mid_reset_fvalid", 32'(fetch_valid), 32'd0);
`ifdef VRAM_ARB_STATS_EN
      chk("stall_after_reset", 32'(stall_count), 32'd0);
`endif
      rst_n = 1; tick();
      idle();
      nf = 0; nc = 0; nw = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         nf += int'(fetch_valid); nc += int'(cpu_rvalid); nw += int'(ram_we);
      end
      chk("post_reset_fvalid", 32'(nf), 32'd0);
      chk("post_reset_rvalid", 32'(nc), 32'd0);
      chk("post_reset_we",     32'(nw), 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst_n  = ($urandom_range(0, 399) != 0);
         f_req  = ($urandom_range(0, 1) == 1);
         f_addr = AW'($urandom_range(0, 15));
         c_req  = ($urandom_range(0, 9) < 6);
         c_we   = ($urandom_range(0, 1) == 1);
         c_addr = AW'($urandom_range(0, 15));
         c_wd   = DW'($urandom);
         clr    = ($urandom_range(0, 49) == 0);
         tick();
      end
      idle(); rst_n = 1;
      for (int i = 0; i < 16; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
